// File: rtl/jtkcpu_busq_pkg.sv
// Shared types and sizing helpers for the KCPU bus front-end.
package jtkcpu_busq_pkg;

   localparam int unsigned AW_DEF  = 24;
   localparam int unsigned DW_DEF  = 8;
   localparam int unsigned QD_DEF  = 4;
   localparam int unsigned TMO_DEF = 0;

   typedef enum logic [1:0] {IDLE, BUS, DONE} bq_state_t;

   // Bytes per bus word (BPW)
   function automatic int unsigned bpw_of(int unsigned dw);
      return dw / 8;
   endfunction

   // Queue pointer width (QW)
   function automatic int unsigned qw_of(int unsigned qd);
      return $clog2(qd);
   endfunction

   // Timeout counter width; must hold TMO-1
   function automatic int unsigned tw_of(int unsigned tmo);
      return (tmo < 2) ? 1 : $clog2(tmo);
   endfunction

endpackage

// File: rtl/jtkcpu_busq_if.sv
// External bus of the KCPU front-end: address/data strobes and dtack handshake.
interface jtkcpu_busq_if #(
   parameter int unsigned AW = 24,
   parameter int unsigned DW = 8
);
   logic [AW-1:0] addr;
   logic [DW-1:0] dout;
   logic [DW-1:0] din;
   logic          we;
   logic          as;
   logic          dtack;

   modport master (output addr, dout, we, as, input din, dtack);
   modport slave  (input addr, dout, we, as, output din, dtack);
endinterface

// File: rtl/jtkcpu_bq_fifo.sv
// Byte FIFO for opcode prefetch: pushes 1 or 2 bytes, pops 1, clears in one clk.
module jtkcpu_bq_fifo
   import jtkcpu_busq_pkg::*;
#(
   parameter int unsigned QD = 4,
   parameter int unsigned QW = qw_of(QD)
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        push,
   input  logic        push2,
   input  logic        pop,
   input  logic [7:0]  wd0,
   input  logic [7:0]  wd1,
   output logic [7:0]  head,
   output logic [QW:0] count,
   output logic [QW:0] free
);

   logic [7:0]    mem [QD];
   logic [QW-1:0] rd_ptr;
   logic [QW-1:0] wr_ptr;
   logic [1:0]    nin;
   logic          do_pop;

   always_comb begin
      nin    = push ? (push2 ? 2'd2 : 2'd1) : 2'd0;
      do_pop = pop && (count != '0) && !clr;
      head   = mem[rd_ptr];
      free   = (QW+1)'(QD) - count;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + QW'(nin);
         if (do_pop) rd_ptr <= rd_ptr + QW'(1);
         count  <= count + (QW+1)'(nin) - (QW+1)'(do_pop);
      end
   end

   // Storage is not reset; count gates every read of it
   always_ff @(posedge clk) begin
      if (push && !clr) begin
         mem[wr_ptr] <= wd0;
         if (push2) mem[wr_ptr + QW'(1)] <= wd1;
      end
   end

endmodule

// File: rtl/jtkcpu_busq.sv
// KCPU bus front-end: opcode prefetch queue, 8/16-bit bus, dtack wait states
// with optional timeout. Data accesses win over prefetch.
module jtkcpu_busq
   import jtkcpu_busq_pkg::*;
#(
   parameter int unsigned AW  = AW_DEF,
   parameter int unsigned DW  = DW_DEF,
   parameter int unsigned QD  = QD_DEF,
   parameter int unsigned TMO = TMO_DEF
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          halt,
   input  logic          flush,
   input  logic [15:0]   new_pc,
   input  logic [AW-17:0] lines,
   input  logic          op_rd,
   output logic [7:0]    op_dout,
   output logic          op_ok,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_din,
   output logic [DW-1:0] d_dout,
   output logic          d_ack,
   output logic          bus_err,
   jtkcpu_busq_if.master bus
);

   localparam int unsigned BPW = bpw_of(DW);
   localparam int unsigned QW  = qw_of(QD);
   localparam int unsigned TW  = tw_of(TMO);
   localparam logic [TW-1:0] TLAST = TW'((TMO == 0) ? 0 : TMO - 1);

   bq_state_t     state;
   logic          is_data;
   logic          tag;
   logic          epoch;
   logic          timed_out;
   logic [15:0]   fptr;
   logic [DW-1:0] rdata;
   logic [TW-1:0] tcnt;

   logic [QW:0]   q_count;
   logic [QW:0]   q_free;
   logic [15:0]   start_ptr;
   logic [QW:0]   avail;
   logic          fetch_push;
   logic          push2;
   logic [7:0]    wd0;

   // A flush on the same edge as a fetch start redirects that fetch
   always_comb begin
      start_ptr = flush ? new_pc : fptr;
      if (BPW == 2) start_ptr[0] = 1'b0;
      avail      = flush ? (QW+1)'(QD) : q_free;
      fetch_push = cen && (state == DONE) && !is_data && !timed_out &&
                   (tag == epoch) && !flush;
      push2      = fetch_push && (BPW == 2) && !fptr[0];
      wd0        = push2 ? rdata[DW-1 -: 8] : rdata[7:0];
      op_ok      = (q_count != '0);
   end

   jtkcpu_bq_fifo #(.QD(QD), .QW(QW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (fetch_push),
      .push2 (push2),
      .pop   (op_rd && !flush),
      .wd0   (wd0),
      .wd1   (rdata[7:0]),
      .head  (op_dout),
      .count (q_count),
      .free  (q_free)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         is_data   <= 1'b0;
         tag       <= 1'b0;
         epoch     <= 1'b0;
         timed_out <= 1'b0;
         fptr      <= '0;
         rdata     <= '0;
         tcnt      <= '0;
         bus.addr  <= '0;
         bus.dout  <= '0;
         bus.we    <= 1'b0;
         bus.as    <= 1'b0;
         d_dout    <= '0;
         d_ack     <= 1'b0;
         bus_err   <= 1'b0;
      end else begin
         d_ack   <= 1'b0;
         bus_err <= 1'b0;
         if (flush) begin
            fptr  <= new_pc;
            epoch <= ~epoch;
         end else if (fetch_push) begin
            fptr <= fptr + (push2 ? 16'd2 : 16'd1);
         end
         if (cen) begin
            case (state)
               IDLE: if (!halt) begin
                  if (d_req) begin
                     bus.addr <= d_addr;
                     bus.we   <= d_we;
                     bus.dout <= d_din;
                     bus.as   <= 1'b1;
                     is_data  <= 1'b1;
                     tcnt     <= '0;
                     state    <= BUS;
                  end else if (avail >= (QW+1)'(BPW)) begin
                     bus.addr <= {lines, start_ptr};
                     bus.we   <= 1'b0;
                     bus.as   <= 1'b1;
                     is_data  <= 1'b0;
                     tag      <= flush ? ~epoch : epoch;
                     tcnt     <= '0;
                     state    <= BUS;
                  end
               end
               BUS: begin
                  if (bus.dtack) begin
                     rdata     <= bus.din;
                     timed_out <= 1'b0;
                     state     <= DONE;
                  end else if ((TMO != 0) && (tcnt == TLAST)) begin
                     timed_out <= 1'b1;
                     state     <= DONE;
                  end else begin
                     tcnt <= tcnt + TW'(1);
                  end
               end
               DONE: begin
                  bus.as  <= 1'b0;
                  bus.we  <= 1'b0;
                  bus_err <= timed_out;
                  if (is_data) begin
                     d_ack  <= 1'b1;
                     d_dout <= timed_out ? '1 : rdata;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/jtkcpu_busq.md
Name: jtkcpu_busq

Overview:
- Parametrised bus front-end for the KCPU family, the next generation of the CPU memory path.
- Sits between the core control/memory logic and the external bus.
- Adds three things: a byte-wide opcode prefetch queue, 8- or 16-bit bus width, and a dtack wait-state handshake with an optional timeout.
- Data accesses from the core take priority over prefetch. All bus activity advances only on cen.

Parameters:
- AW, 24: external address width. Upper AW-16 bits come from lines.
- DW, 8: bus data width. Legal values are 8 or 16. At 16 the bus is big-endian: the even byte is on [15:8].
- QD, 4: prefetch queue depth in bytes. Power of two, 2..16, and QD >= DW/8.
- TMO, 0: dtack timeout in cen cycles. 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cen  in  1  bus step enable
- halt  in  1  blocks start of new bus cycles
- flush  in  1  discard queue; restart fetch at {lines,new_pc}
- new_pc  in  16  fetch restart address
- lines  in  AW-16  upper address bits used for fetches
- op_rd  in  1  pop one byte from the queue
- op_dout  out  8  byte at the queue head
- op_ok  out  1  queue not empty
- d_req  in  1  data access request, level; held until d_ack
- d_we  in  1  data write
- d_addr  in  AW  data address
- d_din  in  DW  write data
- d_dout  out  DW  read data, valid with d_ack
- d_ack  out  1  one-clk pulse when a data access completes
- addr  out  AW  bus address
- dout  out  DW  bus write data
- din  in  DW  bus read data
- we  out  1  bus write strobe
- as  out  1  address strobe; high for the whole bus cycle
- dtack  in  1  bus cycle acknowledge
- bus_err  out  1  one-clk pulse on timeout

Behaviour:
- Reset values: all outputs 0. Queue empty, fetch pointer 0, state IDLE, epoch 0.
- All state changes below happen on a clk edge with cen high, except queue pop and the d_ack/bus_err pulse widths, which are clk-based.
- States: IDLE, BUS, DONE.
- IDLE, choice of cycle (only when halt=0):
  - d_req=1: start a data cycle. Latch d_addr/d_we/d_din into addr/we/dout and set as=1.
  - Otherwise, if queue free space >= DW/8: start a fetch cycle. addr = fetch pointer, word-aligned when DW=16; we=0; as=1. Record the current epoch.
  - Otherwise stay in IDLE.
- BUS:
  - dtack=1: latch din and go to DONE.
  - TMO>0 and TMO cen cycles without dtack: go to DONE, pulse bus_err. d_dout = all ones for a data cycle; fetch data is discarded.
- DONE: clear as and we, then go to IDLE.
  - Data cycle: d_ack pulses 1 clk with d_dout.
  - Fetch cycle, tag equal to epoch: push the bytes and advance the fetch pointer. For DW=16 push 2 bytes, high byte first. If the fetch pointer is odd, push only the low byte. The pointer wraps mod 2^16 within the lines page.
  - Fetch cycle, stale tag: push nothing.
- Minimum bus cycle is 3 cen cycles with zero wait states. A cycle already in progress is never pre-empted by d_req, halt or flush.
- flush:
  - Same clk: queue becomes empty, fetch pointer = new_pc, epoch toggles.
  - op_ok falls next clk.
  - op_rd in the same clk as flush is ignored.
- Queue:
  - Push and pop in the same clk are both honoured; the count is unchanged.
  - op_rd while empty is ignored. Push when full cannot occur because of the free-space rule.
  - op_dout is combinational from the head entry.
- d_req with halt=1 waits; no d_ack until halt falls.
- rst during BUS: as and we drop immediately. The cycle is abandoned and there is no d_ack.

Decomposition:
- Package jtkcpu_busq_pkg holds:
  - state enum IDLE/BUS/DONE;
  - localparams BPW = DW/8 and QW = log2(QD);
  - the timeout counter width.
- One sub-module, jtkcpu_bq_fifo: byte FIFO with depth QD. It provides push of 1 or 2 bytes, pop, clear, a count output and a free output.

Test Plan:
- DW=8, QD=4, dtack tied high, flush new_pc=0x1000, lines=0x00, no op_rd -> fetches 0x1000..0x1003, then idle with as low; op_ok=1; op_dout = byte from 0x1000.
- DW=8, d_req read 0x2345 while a fetch is in progress, dtack delayed 2 cen -> the fetch completes first; the data cycle follows; d_ack pulses once with d_dout = din.
- DW=16, flush to 0x1001, din=0xAABB then 0xCCDD -> the queue receives BB, CC, DD in order; first addr = 0x1000, second = 0x1002.
- Flush during a fetch BUS state at 0x1002, new_pc=0x4000 -> the old fetch data is discarded; the next fetch addr is 0x4000; the queue holds only 0x4000-stream bytes.
- TMO=8, d_req write, dtack never asserted -> bus_err and d_ack pulse after 8 cen; as falls; the next cycle starts normally.
- halt=1 with d_req pending -> as stays 0; release halt -> the data cycle starts on the next cen.
